// File: rtl/markov_pkg.sv
// Shared definitions for the Markov transition learner: FSM state encoding,
// the table entry layout and the index-width helper.
package markov_pkg;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        WAIT_SYM = 3'd1,
        CHECK    = 3'd2,
        INCR     = 3'd3,
        ADD      = 3'd4,
        FINISH   = 3'd5
    } state_e;

    // Entry layout at the default widths; markov_table re-declares the same
    // three fields at its own parameter widths.
    localparam int DEF_SYM_W   = 8;
    localparam int DEF_COUNT_W = 8;

    typedef struct packed {
        logic [DEF_SYM_W-1:0]   prev;
        logic [DEF_SYM_W-1:0]   next;
        logic [DEF_COUNT_W-1:0] count;
    } entry_t;

    function automatic int idx_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/markov_transition_learner_if.sv
// Symbol stream and table read port of the Markov transition learner.
// Handshake: a symbol transfers on a rising edge where sym_valid && sym_ready;
// sym_data/sym_last are held stable while sym_valid waits for sym_ready.
interface markov_transition_learner_if import markov_pkg::*; #(
    parameter int SYM_W   = 8,
    parameter int DEPTH   = 16,
    parameter int COUNT_W = 8
);
    localparam int IDX_W = idx_w(DEPTH);

    logic               sym_valid;
    logic               sym_ready;
    logic [SYM_W-1:0]   sym_data;
    logic               sym_last;

    logic               rd_en;
    logic [IDX_W-1:0]   rd_idx;
    logic               rd_valid;
    logic [SYM_W-1:0]   rd_prev;
    logic [SYM_W-1:0]   rd_next;
    logic [COUNT_W-1:0] rd_count;

    modport master (
        output sym_valid, sym_data, sym_last, rd_en, rd_idx,
        input  sym_ready, rd_valid, rd_prev, rd_next, rd_count
    );

    modport slave (
        input  sym_valid, sym_data, sym_last, rd_en, rd_idx,
        output sym_ready, rd_valid, rd_prev, rd_next, rd_count
    );

endinterface

// File: rtl/markov_table.sv
// DEPTH-entry transition table: one write port, a combinational compare port
// used while searching, and a registered read port gated by the entry count.
module markov_table #(
    parameter int SYM_W   = 8,
    parameter int DEPTH   = 16,
    parameter int COUNT_W = 8,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [SYM_W-1:0]   wr_prev,
    input  logic [SYM_W-1:0]   wr_next,
    input  logic [COUNT_W-1:0] wr_count,
    input  logic [IDX_W-1:0]   cmp_idx,
    output logic [SYM_W-1:0]   cmp_prev,
    output logic [SYM_W-1:0]   cmp_next,
    output logic [COUNT_W-1:0] cmp_count,
    input  logic [IDX_W:0]     entries,
    input  logic               rd_en,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_valid,
    output logic [SYM_W-1:0]   rd_prev,
    output logic [SYM_W-1:0]   rd_next,
    output logic [COUNT_W-1:0] rd_count
);

    typedef struct packed {
        logic [SYM_W-1:0]   prev;
        logic [SYM_W-1:0]   next;
        logic [COUNT_W-1:0] count;
    } entry_t;

    entry_t mem_q [DEPTH];
    entry_t mem_d [DEPTH];
    entry_t rd_q, rd_d;
    logic   rd_valid_q, rd_valid_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = '{prev: wr_prev, next: wr_next, count: wr_count};
        end
    end

    // Reads sample mem_q, so a same-cycle write to the same index is not yet visible.
    always_comb begin
        rd_valid_d = rd_en;
        rd_d       = rd_q;
        if (rd_en) begin
            rd_d = ({1'b0, rd_idx} < entries) ? mem_q[rd_idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign cmp_prev  = mem_q[cmp_idx].prev;
    assign cmp_next  = mem_q[cmp_idx].next;
    assign cmp_count = mem_q[cmp_idx].count;
    assign rd_valid  = rd_valid_q;
    assign rd_prev   = rd_q.prev;
    assign rd_next   = rd_q.next;
    assign rd_count  = rd_q.count;

endmodule

// File: rtl/markov_transition_learner.sv
// First-order Markov transition learner: searches the table per symbol pair and
// increments or appends. Define MARKOV_SATURATE_EN to saturate counts instead of wrapping.
module markov_transition_learner import markov_pkg::*; #(
    parameter  int SYM_W   = 8,
    parameter  int DEPTH   = 16,
    parameter  int COUNT_W = 8,
    localparam int IDX_W   = idx_w(DEPTH)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    markov_transition_learner_if.slave        bus,
    output logic [IDX_W:0]                    entries,
    output logic                              overflow,
    output logic                              done,
    output state_e                            dbg_state
);

    localparam int ENT_W = IDX_W + 1;

    state_e             state_q, state_d;
    logic [ENT_W-1:0]   entries_q, entries_d;
    logic               has_prev_q, has_prev_d;
    logic               overflow_q, overflow_d;
    logic               last_seen_q, last_seen_d;
    logic [SYM_W-1:0]   prev_q, prev_d;
    logic [SYM_W-1:0]   cur_q, cur_d;
    logic [IDX_W-1:0]   i_q, i_d;

    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [COUNT_W-1:0] wr_count;
    logic [SYM_W-1:0]   cmp_prev, cmp_next;
    logic [COUNT_W-1:0] cmp_count;
    logic               match;
    logic               at_last_entry;

    function automatic logic [COUNT_W-1:0] count_inc(input logic [COUNT_W-1:0] c);
`ifdef MARKOV_SATURATE_EN
        return (c == '1) ? c : c + COUNT_W'(1);
`else
        return c + COUNT_W'(1);
`endif
    endfunction

    assign match         = (cmp_prev == prev_q) && (cmp_next == cur_q);
    assign at_last_entry = ({1'b0, i_q} == (entries_q - ENT_W'(1)));

    always_comb begin
        state_d     = state_q;
        entries_d   = entries_q;
        has_prev_d  = has_prev_q;
        overflow_d  = overflow_q;
        last_seen_d = last_seen_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        i_d         = i_q;
        wr_en       = 1'b0;
        wr_idx      = i_q;
        wr_count    = count_inc(cmp_count);

        case (state_q)
            INIT: begin
                entries_d  = '0;
                has_prev_d = 1'b0;
                overflow_d = 1'b0;
                state_d    = WAIT_SYM;
            end
            WAIT_SYM: begin
                if (bus.sym_valid) begin
                    last_seen_d = bus.sym_last;
                    if (!has_prev_q) begin
                        prev_d     = bus.sym_data;
                        has_prev_d = 1'b1;
                        state_d    = bus.sym_last ? FINISH : WAIT_SYM;
                    end else begin
                        cur_d   = bus.sym_data;
                        i_d     = '0;
                        state_d = (entries_q == '0) ? ADD : CHECK;
                    end
                end
            end
            CHECK: begin
                if (match) begin
                    state_d = INCR;
                end else if (at_last_entry) begin
                    state_d = ADD;
                end else begin
                    i_d = i_q + IDX_W'(1);
                end
            end
            INCR: begin
                wr_en   = 1'b1;
                prev_d  = cur_q;
                state_d = last_seen_q ? FINISH : WAIT_SYM;
            end
            ADD: begin
                // A full table drops the new pair but the chain still advances.
                if (entries_q < ENT_W'(DEPTH)) begin
                    wr_en     = 1'b1;
                    wr_idx    = entries_q[IDX_W-1:0];
                    wr_count  = COUNT_W'(1);
                    entries_d = entries_q + ENT_W'(1);
                end else begin
                    overflow_d = 1'b1;
                end
                prev_d  = cur_q;
                state_d = last_seen_q ? FINISH : WAIT_SYM;
            end
            FINISH: begin
                if (start) begin
                    state_d = INIT;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= INIT;
            entries_q   <= '0;
            has_prev_q  <= 1'b0;
            overflow_q  <= 1'b0;
            last_seen_q <= 1'b0;
            prev_q      <= '0;
            cur_q       <= '0;
            i_q         <= '0;
        end else begin
            state_q     <= state_d;
            entries_q   <= entries_d;
            has_prev_q  <= has_prev_d;
            overflow_q  <= overflow_d;
            last_seen_q <= last_seen_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            i_q         <= i_d;
        end
    end

    markov_table #(
        .SYM_W   (SYM_W),
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_prev   (prev_q),
        .wr_next   (cur_q),
        .wr_count  (wr_count),
        .cmp_idx   (i_q),
        .cmp_prev  (cmp_prev),
        .cmp_next  (cmp_next),
        .cmp_count (cmp_count),
        .entries   (entries_q),
        .rd_en     (bus.rd_en),
        .rd_idx    (bus.rd_idx),
        .rd_valid  (bus.rd_valid),
        .rd_prev   (bus.rd_prev),
        .rd_next   (bus.rd_next),
        .rd_count  (bus.rd_count)
    );

    assign bus.sym_ready = (state_q == WAIT_SYM);
    assign done          = (state_q == FINISH);
    assign entries       = entries_q;
    assign overflow      = overflow_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_markov_transition_learner.sv
// Directed bench for markov_transition_learner with SYM_W=4, DEPTH=4, COUNT_W=2:
// table-driven read-back checks plus hand-written timing/reset sequences.
module tb_markov_transition_learner;
    import markov_pkg::*;

    localparam int SYM_W   = 4;
    localparam int DEPTH   = 4;
    localparam int COUNT_W = 2;

    typedef struct {
        logic [1:0] idx;
        logic [3:0] prev;
        logic [3:0] nxt;
        logic [1:0] cnt;
    } rd_vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [2:0] entries;
    logic       overflow;
    logic       done;
    state_e     dbg_state;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    rd_vec_t tab_basic [4];
    rd_vec_t tab_ovf   [4];
    rd_vec_t tab_sat   [4];
    rd_vec_t tab_zero  [4];

    markov_transition_learner_if #(.SYM_W(SYM_W), .DEPTH(DEPTH), .COUNT_W(COUNT_W)) bus ();

    markov_transition_learner #(.SYM_W(SYM_W), .DEPTH(DEPTH), .COUNT_W(COUNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .entries   (entries),
        .overflow  (overflow),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_sym(input logic [3:0] s, input logic l);
        int n = 0;
        bus.sym_valid = 1'b1;
        bus.sym_data  = s;
        bus.sym_last  = l;
        while (!bus.sym_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("sym_ready timeout", 32'(bus.sym_ready), 32'd1);
        @(negedge clk);
        bus.sym_valid = 1'b0;
        bus.sym_last  = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] idx, output logic v, output logic [3:0] p,
                           output logic [3:0] nx, output logic [1:0] c);
        bus.rd_en  = 1'b1;
        bus.rd_idx = idx;
        @(negedge clk);
        v  = bus.rd_valid;
        p  = bus.rd_prev;
        nx = bus.rd_next;
        c  = bus.rd_count;
        bus.rd_en = 1'b0;
    endtask

    task automatic run_table(input rd_vec_t t [4], input string tag);
        logic       v;
        logic [3:0] p, nx;
        logic [1:0] c;
        for (int k = 0; k < 4; k++) begin
            do_read(t[k].idx, v, p, nx, c);
            check($sformatf("%s[%0d] rd_valid", tag, k), 32'(v), 32'd1);
            check($sformatf("%s[%0d] rd_prev", tag, k), 32'(p), 32'(t[k].prev));
            check($sformatf("%s[%0d] rd_next", tag, k), 32'(nx), 32'(t[k].nxt));
            check($sformatf("%s[%0d] rd_count", tag, k), 32'(c), 32'(t[k].cnt));
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("done reached", 32'(done), 32'd1);
    endtask

    task automatic restart();
        start = 1'b1;
        @(negedge clk);
        check("restart done low", 32'(done), 32'd0);
        check("restart state", 32'(dbg_state), 32'(INIT));
        start = 1'b0;
        @(negedge clk);
        check("restart sym_ready", 32'(bus.sym_ready), 32'd1);
        check("restart entries", 32'(entries), 32'd0);
        check("restart overflow", 32'(overflow), 32'd0);
    endtask

    initial begin
        int lat;
        logic [1:0] sat_cnt;
`ifdef MARKOV_SATURATE_EN
        sat_cnt = 2'd3;
`else
        sat_cnt = 2'd1;
`endif
        tab_basic[0] = '{2'd0, 4'd1, 4'd2, 2'd2};
        tab_basic[1] = '{2'd1, 4'd2, 4'd1, 2'd1};
        tab_basic[2] = '{2'd2, 4'd0, 4'd0, 2'd0};
        tab_basic[3] = '{2'd3, 4'd0, 4'd0, 2'd0};
        tab_ovf[0]   = '{2'd0, 4'd0, 4'd1, 2'd1};
        tab_ovf[1]   = '{2'd1, 4'd1, 4'd2, 2'd1};
        tab_ovf[2]   = '{2'd2, 4'd2, 4'd3, 2'd1};
        tab_ovf[3]   = '{2'd3, 4'd3, 4'd4, 2'd1};
        tab_sat[0]   = '{2'd0, 4'd7, 4'd7, sat_cnt};
        tab_sat[1]   = '{2'd1, 4'd0, 4'd0, 2'd0};
        tab_sat[2]   = '{2'd2, 4'd0, 4'd0, 2'd0};
        tab_sat[3]   = '{2'd3, 4'd0, 4'd0, 2'd0};
        for (int k = 0; k < 4; k++) tab_zero[k] = '{2'(k), 4'd0, 4'd0, 2'd0};

        bus.sym_valid = 1'b0;
        bus.sym_data  = '0;
        bus.sym_last  = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_idx    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset sym_ready", 32'(bus.sym_ready), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset entries", 32'(entries), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset rd_valid", 32'(bus.rd_valid), 32'd0);
        check("reset state", 32'(dbg_state), 32'(INIT));
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("post-reset sym_ready", 32'(bus.sym_ready), 32'd1);

        // Stream 1,2,1,2(last); last pair matches entry 0 (k=0)
        send_sym(4'd1, 1'b0);
        check("first symbol keeps ready", 32'(bus.sym_ready), 32'd1);
        send_sym(4'd2, 1'b0);
        send_sym(4'd1, 1'b0);
        send_sym(4'd2, 1'b1);
        check("match cycle1 state", 32'(dbg_state), 32'(CHECK));
        check("match cycle1 ready", 32'(bus.sym_ready), 32'd0);
        @(negedge clk);
        check("match cycle2 state", 32'(dbg_state), 32'(INCR));
        bus.rd_en  = 1'b1;
        bus.rd_idx = 2'd0;
        @(negedge clk);
        bus.rd_en = 1'b0;
        check("rd during incr valid", 32'(bus.rd_valid), 32'd1);
        check("rd during incr old count", 32'(bus.rd_count), 32'd1);
        check("done after last incr", 32'(done), 32'd1);
        @(negedge clk);
        check("rd_valid pulse", 32'(bus.rd_valid), 32'd0);
        check("basic entries", 32'(entries), 32'd2);
        check("basic overflow", 32'(overflow), 32'd0);
        run_table(tab_basic, "basic");

        // Table overflow: 0..5, pair (4,5) dropped
        restart();
        for (int s = 0; s < 5; s++) send_sym(4'(s), 1'b0);
        send_sym(4'd5, 1'b1);
        wait_done(lat);
        check("miss n=4 latency to done", 32'(lat), 32'd5);
        check("ovf entries", 32'(entries), 32'd4);
        check("ovf overflow", 32'(overflow), 32'd1);
        run_table(tab_ovf, "ovf");

        // Count wrap / saturation: five (7,7) pairs
        restart();
        for (int s = 0; s < 5; s++) send_sym(4'd7, 1'b0);
        send_sym(4'd7, 1'b1);
        wait_done(lat);
        check("sat entries", 32'(entries), 32'd1);
        check("sat overflow", 32'(overflow), 32'd0);
        run_table(tab_sat, "sat");

        // Asynchronous reset while searching with 3 entries
        restart();
        for (int s = 0; s < 4; s++) send_sym(4'(s), 1'b0);
        send_sym(4'd5, 1'b0);
        check("pre-reset state", 32'(dbg_state), 32'(CHECK));
        check("pre-reset entries", 32'(entries), 32'd3);
        reset = 1'b0;
        #1;
        check("async reset entries", 32'(entries), 32'd0);
        check("async reset state", 32'(dbg_state), 32'(INIT));
        check("async reset ready", 32'(bus.sym_ready), 32'd0);
        check("async reset done", 32'(done), 32'd0);
        check("async reset overflow", 32'(overflow), 32'd0);
        check("async reset rd_valid", 32'(bus.rd_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("after reset entries", 32'(entries), 32'd0);
        check("after reset ready", 32'(bus.sym_ready), 32'd1);

        // Single symbol with last
        send_sym(4'd9, 1'b1);
        check("single done", 32'(done), 32'd1);
        check("single state", 32'(dbg_state), 32'(FINISH));
        check("single entries", 32'(entries), 32'd0);
        run_table(tab_zero, "single");
        restart();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
